// File: rtl/aha_pctrl_regbank_gen.sv
// Platform-controller register bank: AHB-Lite slave driving per-channel clock select,
// clock gate and reset req/ack handshakes with timeout tracking.
//  state    | meaning
//  ST_IDLE  | no handshake, RESET_REQ_o low
//  ST_REQ   | RESET_REQ_o high, waiting for ack or timeout
//  ST_REL   | request released, waiting for ack to drop
module aha_pctrl_regbank_gen #(
    parameter int NUM_CH    = 11,
    parameter int SEL_W     = 3,
    parameter int TIMEOUT_W = 8,
    parameter int ADDR_W    = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HSEL,
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [31:0]               HWDATA,
    input  logic                      HREADYMUX,
    output logic [31:0]               HRDATA,
    output logic                      HREADYOUT,
    output logic [1:0]                HRESP,
    output logic [NUM_CH*SEL_W-1:0]   CLK_SEL_o,
    output logic [NUM_CH-1:0]         CLK_GATE_EN_o,
    output logic [NUM_CH-1:0]         RESET_REQ_o,
    input  logic [NUM_CH-1:0]         RESET_ACK_i,
    output logic                      IRQ_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    localparam logic [ADDR_W-1:0] A_ID    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_GATE  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CMD   = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] A_STS   = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] A_LIMIT = ADDR_W'(16);
    localparam logic [ADDR_W-1:0] A_IRQEN = ADDR_W'(20);
    localparam logic [ADDR_W-1:0] A_SEL0  = ADDR_W'(256);

    logic                    dp_valid, dp_write, err1, err2, irq;
    logic [ADDR_W-1:0]       dp_addr;
    logic [NUM_CH-1:0]       gate_en, irq_en, to_sts, to_set, busy;
    logic [TIMEOUT_W-1:0]    to_limit;
    logic [NUM_CH*SEL_W-1:0] clk_sel;
    logic [1:0]              ch_state [NUM_CH];
    logic [TIMEOUT_W-1:0]    ch_cnt   [NUM_CH];
    logic [ADDR_W-1:0]       sel_idx;
    logic                    addr_hit, addr_ok, wr, sel_hit;
    logic [31:0]             rdata;

    function automatic logic addr_mapped(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] rel;
        rel = a - A_SEL0;
        return (a <= A_IRQEN) || ((a >= A_SEL0) && (rel < ADDR_W'(4 * NUM_CH)));
    endfunction

    assign addr_hit = HSEL & HTRANS[1] & HREADYMUX;
    assign addr_ok  = addr_mapped(HADDR) && (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00);

    // Errored transfers never open a data phase, so they cannot write or return data.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            err1     <= 1'b0;
            err2     <= 1'b0;
        end else begin
            dp_valid <= addr_hit & addr_ok;
            dp_write <= HWRITE;
            dp_addr  <= HADDR;
            err1     <= addr_hit & ~addr_ok;
            err2     <= err1;
        end
    end

    assign HREADYOUT = ~err1;
    assign HRESP     = {1'b0, err1 | err2};

    assign wr      = dp_valid & dp_write;
    assign sel_hit = dp_addr >= A_SEL0;
    assign sel_idx = (dp_addr - A_SEL0) >> 2;

    always_comb begin
        to_set = '0;
        busy   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i]   = ch_state[i] != ST_IDLE;
            to_set[i] = (ch_state[i] == ST_REQ) && !RESET_ACK_i[i] && (ch_cnt[i] == to_limit);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            gate_en  <= '1;
            irq_en   <= '0;
            to_limit <= '1;
            clk_sel  <= '0;
            to_sts   <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && dp_addr == A_GATE)  gate_en  <= HWDATA[NUM_CH-1:0];
            if (wr && dp_addr == A_IRQEN) irq_en   <= HWDATA[NUM_CH-1:0];
            if (wr && dp_addr == A_LIMIT) to_limit <= HWDATA[TIMEOUT_W-1:0];
            for (int i = 0; i < NUM_CH; i++)
                if (wr && sel_hit && sel_idx == ADDR_W'(i))
                    clk_sel[i*SEL_W +: SEL_W] <= HWDATA[SEL_W-1:0];
            // A timeout landing on the same cycle as a W1C survives the clear.
            to_sts <= (to_sts & ~((wr && dp_addr == A_STS) ? HWDATA[NUM_CH-1:0] : '0)) | to_set;
            irq    <= |(to_sts & irq_en);
        end
    end

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (HRESET) begin
                ch_state[i] <= ST_IDLE;
                ch_cnt[i]   <= '0;
            end else begin
                case (ch_state[i])
                    ST_IDLE: if (wr && dp_addr == A_CMD && HWDATA[i]) begin
                        ch_state[i] <= ST_REQ;
                        ch_cnt[i]   <= '0;
                    end
                    ST_REQ: begin
                        if (RESET_ACK_i[i])       ch_state[i] <= ST_REL;
                        else if (to_set[i])       ch_state[i] <= ST_IDLE;
                        if (ch_cnt[i] != '1)      ch_cnt[i]   <= ch_cnt[i] + 1'b1;
                    end
                    ST_REL:  if (!RESET_ACK_i[i]) ch_state[i] <= ST_IDLE;
                    default: ch_state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (dp_valid && !dp_write) begin
            if (dp_addr == A_ID)         rdata = {16'hAC01, 8'(SEL_W), 8'(NUM_CH)};
            else if (dp_addr == A_GATE)  rdata[NUM_CH-1:0] = gate_en;
            else if (dp_addr == A_CMD)   rdata[NUM_CH-1:0] = busy;
            else if (dp_addr == A_STS)   rdata[NUM_CH-1:0] = to_sts;
            else if (dp_addr == A_LIMIT) rdata[TIMEOUT_W-1:0] = to_limit;
            else if (dp_addr == A_IRQEN) rdata[NUM_CH-1:0] = irq_en;
            else if (sel_hit) begin
                for (int i = 0; i < NUM_CH; i++)
                    if (sel_idx == ADDR_W'(i)) rdata[SEL_W-1:0] = clk_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        RESET_REQ_o = '0;
        for (int i = 0; i < NUM_CH; i++) RESET_REQ_o[i] = ch_state[i] == ST_REQ;
    end

    assign HRDATA        = rdata;
    assign CLK_SEL_o     = clk_sel;
    assign CLK_GATE_EN_o = gate_en;
    assign IRQ_o         = irq;

    logic unused_bits;
    assign unused_bits = &{1'b0, HWDATA, HTRANS[0]};

endmodule
